fetch_pc_unit: RTL and testbench

- Instruction-fetch front end; sits directly upstream of BranchPredictor.
- Owns the architectural fetch PC and presents it to the predictor each cycle.
- Uses the predictor's prediction/predicted_address to pick the next PC, issues in-order requests to instruction memory, and buffers returned instructions for decode.
- Handles execute-stage redirects (mispredict/exception), squashing wrong-path in-flight fetches.

---
 rtl/fetch_pc_unit.sv | 213 +++++++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch front end feeding the BranchPredictor.
// Owns the fetch PC and issues in-order requests to instruction memory.
// It uses an in-flight tag FIFO and buffers returned words for decode.
// Execute-stage redirects squash wrong-path fetches through a drop counter.
// Optional feature macro: FETCH_PERF_CNT_EN adds the perf_fetched,
// perf_squashed and perf_stall free-running counters.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] bp_pc,
  input  logic        bp_prediction,
  input  logic [31:0] bp_predicted_address,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  output logic        fetch_pred_taken
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed,
  output logic [31:0] perf_stall
`endif
);

  // Pointer width (BUF_DEPTH is a power of two, so pointers wrap naturally)
  // and count width (counts run 0..BUF_DEPTH inclusive).
  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);

  // Architectural fetch PC.
  logic [31:0]   pc_q, pc_d;

  // In-flight tag FIFO: one entry per accepted request, popped per response.
  logic [31:0]   tag_pc_mem   [BUF_DEPTH];
  logic          tag_pred_mem [BUF_DEPTH];
  logic [AW-1:0] tag_wr_q, tag_wr_d;
  logic [AW-1:0] tag_rd_q, tag_rd_d;
  logic [CW-1:0] inflight_q, inflight_d;

  // Responses still owed to us from squashed (wrong-path) requests.
  logic [CW-1:0] drop_q, drop_d;

  // Instruction buffer presented to decode.
  logic [31:0]   buf_pc_mem    [BUF_DEPTH];
  logic          buf_pred_mem  [BUF_DEPTH];
  logic [31:0]   buf_instr_mem [BUF_DEPTH];
  logic [AW-1:0] buf_wr_q, buf_wr_d;
  logic [AW-1:0] buf_rd_q, buf_rd_d;
  logic [CW-1:0] occ_q, occ_d;

  // Per-cycle events.
  logic req_fire;
  logic resp_drop;
  logic resp_keep;
  logic head_pop;

  // The low two bits of incoming addresses are forced to zero (word aligned).
  logic unused_low_bits;
  assign unused_low_bits = ^{bp_predicted_address[1:0], redirect_pc[1:0]};

  // Request side: the PC is offered every cycle, gated by the credit rule so
  // that outstanding requests plus buffered words never exceed the buffer.
  assign bp_pc          = pc_q;
  assign imem_req_addr  = pc_q;
  assign imem_req_valid = !reset && !redirect_valid &&
                          (({1'b0, inflight_q} + {1'b0, occ_q}) < DEPTH_W);

  // Decode side: head of the buffer, forced to zero while empty.
  assign fetch_valid      = (occ_q != '0);
  assign fetch_instr      = fetch_valid ? buf_instr_mem[buf_rd_q] : 32'd0;
  assign fetch_pc         = fetch_valid ? buf_pc_mem[buf_rd_q]    : 32'd0;
  assign fetch_pred_taken = fetch_valid ? buf_pred_mem[buf_rd_q]  : 1'b0;

  // Classify this cycle's handshakes and compute every next-state value.
  always_comb begin
    req_fire   = imem_req_valid && imem_req_ready;
    resp_drop  = imem_resp_valid && ((drop_q != '0) || redirect_valid);
    resp_keep  = imem_resp_valid && (drop_q == '0) && !redirect_valid;
    head_pop   = fetch_valid && fetch_ready;

    pc_d       = pc_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    buf_wr_d   = buf_wr_q;
    buf_rd_d   = buf_rd_q;
    occ_d      = occ_q;

    // Tag FIFO moves on every accept and every response (kept or dropped).
    if (req_fire) begin
      tag_wr_d = tag_wr_q + AW'(1);
    end
    if (imem_resp_valid) begin
      tag_rd_d = tag_rd_q + AW'(1);
    end
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_resp_valid);

    if (redirect_valid) begin
      // Every request still outstanding after this cycle is wrong-path.
      // Any response arriving now has already been retired from the tag
      // FIFO, so it is subtracted whether or not it was itself a drop; this
      // keeps the drop count from ever exceeding the in-flight count.
      pc_d     = {redirect_pc[31:2], 2'b00};
      drop_d   = inflight_q - CW'(imem_resp_valid);
      buf_rd_d = buf_wr_q;
      occ_d    = '0;
    end else begin
      if (req_fire) begin
        pc_d = bp_prediction ? {bp_predicted_address[31:2], 2'b00}
                             : pc_q + 32'd4;
      end
      if (resp_drop) begin
        drop_d = drop_q - CW'(1);
      end
      if (resp_keep) begin
        buf_wr_d = buf_wr_q + AW'(1);
      end
      if (head_pop) begin
        buf_rd_d = buf_rd_q + AW'(1);
      end
      occ_d = occ_q + CW'(resp_keep) - CW'(head_pop);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      buf_wr_q   <= '0;
      buf_rd_q   <= '0;
      occ_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      buf_wr_q   <= buf_wr_d;
      buf_rd_q   <= buf_rd_d;
      occ_q      <= occ_d;
    end
  end

  // Storage writes: tag on accept, buffer entry on a kept response.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_pc_mem[tag_wr_q]   <= pc_q;
      tag_pred_mem[tag_wr_q] <= bp_prediction;
    end
    if (resp_keep) begin
      buf_pc_mem[buf_wr_q]    <= tag_pc_mem[tag_rd_q];
      buf_pred_mem[buf_wr_q]  <= tag_pred_mem[tag_rd_q];
      buf_instr_mem[buf_wr_q] <= imem_resp_data;
    end
  end

  // A response with nothing outstanding means memory and fetch disagree.
  resp_without_request: assert property (
    @(posedge clk) disable iff (reset)
      !(imem_resp_valid && (inflight_q == '0))
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_squashed_q, perf_squashed_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Counter increments: pops, squashed words (dropped or flushed), stalls.
  always_comb begin
    perf_fetched_d  = perf_fetched_q + 32'(head_pop);
    perf_squashed_d = perf_squashed_q + 32'(resp_drop);
    if (redirect_valid) begin
      perf_squashed_d = perf_squashed_d + 32'(occ_q) - 32'(head_pop);
    end
    perf_stall_d    = perf_stall_q + 32'(imem_req_valid && !imem_req_ready);
  end

  // Free-running performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q  <= '0;
      perf_squashed_q <= '0;
      perf_stall_q    <= '0;
    end else begin
      perf_fetched_q  <= perf_fetched_d;
      perf_squashed_q <= perf_squashed_d;
      perf_stall_q    <= perf_stall_d;
    end
  end

  assign perf_fetched  = perf_fetched_q;
  assign perf_squashed = perf_squashed_q;
  assign perf_stall    = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Testbench for fetch_pc_unit: table-driven sequential fetch, directed
// corner-case sequences, then randomized traffic against a queue-based model
// that tracks wrong-path requests by redirect epoch.
module tb_fetch_pc_unit;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] bp_pc;
  logic        bp_prediction;
  logic [31:0] bp_predicted_address;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_pred_taken;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_squashed, perf_stall;
`endif

  fetch_pc_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .bp_pc(bp_pc), .bp_prediction(bp_prediction),
    .bp_predicted_address(bp_predicted_address),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_pred_taken(fetch_pred_taken)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed),
    .perf_stall(perf_stall)
`endif
  );

  // Reference model: memory pending list doubles as the in-flight list.
  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] data;
    int          rdy;
    int          epoch;
  } pend_t;
  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] data;
  } ent_t;

  pend_t       pend_q[$];
  ent_t        buf_q[$];
  logic [31:0] m_pc;
  int          epoch;
  int          cyc;
  int          lat;
  int          n_pass;
  int          n_total;
  logic [31:0] popped_pc[$];
  logic        popped_pred[$];

  // Outputs captured by the most recent step.
  logic        o_req;
  logic [31:0] o_bppc;
  logic        o_fv;
  logic [31:0] o_fpc;
  logic        o_fpred;

  typedef struct {
    logic        rdy;
    logic        fr;
    logic        pr;
    logic [31:0] pa;
    logic        e_req;
    logic [31:0] e_bppc;
    logic        e_fv;
    logic [31:0] e_fpc;
    logic        e_fpred;
  } vec_t;
  vec_t tbl[6];

  function automatic logic [31:0] z(input logic b);
    return {31'b0, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
  endtask

  // One clock cycle: drive inputs, compare against the model, advance model.
  task automatic step(input logic rst, input logic rdy, input logic fr,
                      input logic pr, input logic [31:0] pa,
                      input logic rd, input logic [31:0] rp);
    logic  e_req;
    logic  resp;
    logic  fire;
    pend_t h;
    if (rst) pend_q.delete();
    resp = !rst && (pend_q.size() > 0) && (pend_q[0].rdy <= cyc);
    reset                = rst;
    imem_req_ready       = rdy;
    fetch_ready          = fr;
    bp_prediction        = pr;
    bp_predicted_address = pa;
    redirect_valid       = rd;
    redirect_pc          = rp;
    imem_resp_valid      = resp;
    imem_resp_data       = resp ? pend_q[0].data : $urandom;
    e_req = !rst && !rd && ((pend_q.size() + buf_q.size()) < DEPTH);
    @(negedge clk);
    o_req = imem_req_valid; o_bppc = bp_pc; o_fv = fetch_valid;
    o_fpc = fetch_pc; o_fpred = fetch_pred_taken;
    check("req_valid", z(imem_req_valid), z(e_req));
    if (!rst) begin
      check("bp_pc", bp_pc, m_pc);
      check("req_addr", imem_req_addr, m_pc);
      check("fetch_valid", z(fetch_valid), z(buf_q.size() > 0));
      if (buf_q.size() > 0) begin
        check("fetch_instr", fetch_instr, buf_q[0].data);
        check("fetch_pc", fetch_pc, buf_q[0].pc);
        check("fetch_pred", z(fetch_pred_taken), z(buf_q[0].pred));
      end else begin
        check("empty_instr", fetch_instr, 32'd0);
        check("empty_pc", fetch_pc, 32'd0);
        check("empty_pred", z(fetch_pred_taken), 32'd0);
      end
      if (fetch_valid && fr) begin
        popped_pc.push_back(fetch_pc);
        popped_pred.push_back(fetch_pred_taken);
      end
    end
    if (rst) begin
      m_pc = RPC;
      buf_q.delete();
      epoch++;
    end else begin
      fire = e_req && rdy;
      if (buf_q.size() > 0 && fr) void'(buf_q.pop_front());
      if (resp) begin
        h = pend_q.pop_front();
        if (!rd && h.epoch == epoch) buf_q.push_back('{h.pc, h.pred, h.data});
      end
      if (rd) begin
        epoch++;
        buf_q.delete();
        m_pc = {rp[31:2], 2'b00};
      end else if (fire) begin
        pend_q.push_back('{m_pc, pr, $urandom, cyc + lat, epoch});
        m_pc = pr ? {pa[31:2], 2'b00} : m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    lat = 1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    popped_pc.delete();
    popped_pred.delete();
  endtask

  task automatic run(input int n, input logic fr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, fr, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0; lat = 1; epoch = 0; m_pc = RPC;
    reset = 1'b1; imem_req_ready = 1'b0; fetch_ready = 1'b0;
    bp_prediction = 1'b0; bp_predicted_address = '0; redirect_valid = 1'b0;
    redirect_pc = '0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    @(posedge clk);
    #1;

    // Sequential fetch, 1-cycle memory, decode always ready.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h104, 1'b0, 32'h0,   1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'h108, 1'b1, 32'h100, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h108, 1'b1, 32'h104, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h10C, 1'b0, 32'h0,   1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'h110, 1'b1, 32'h108, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, tbl[i].rdy, tbl[i].fr, tbl[i].pr, tbl[i].pa, 1'b0, 32'd0);
      check("tbl_req", z(o_req), z(tbl[i].e_req));
      check("tbl_bppc", o_bppc, tbl[i].e_bppc);
      check("tbl_fv", z(o_fv), z(tbl[i].e_fv));
      check("tbl_fpc", o_fpc, tbl[i].e_fpc);
      check("tbl_fpred", z(o_fpred), z(tbl[i].e_fpred));
    end

    // Predicted taken at 0x104 toward 0x202 (aligned to 0x200).
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h202, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    check("taken_bppc", o_bppc, 32'h200);
    run(6, 1'b1);
    check("taken_seq0", popped_pc[0], 32'h100);
    check("taken_seq1", popped_pc[1], 32'h104);
    check("taken_pred1", z(popped_pred[1]), 32'd1);
    check("taken_seq2", popped_pc[2], 32'h200);
    check("taken_pred2", z(popped_pred[2]), 32'd0);

    // Backpressure: decode stalls for 6 cycles, then drains in order.
    do_reset();
    run(6, 1'b0);
    check("bp_req_low", z(o_req), 32'd0);
    check("bp_head_held", o_fpc, 32'h100);
    run(6, 1'b1);
    check("bp_seq0", popped_pc[0], 32'h100);
    check("bp_seq1", popped_pc[1], 32'h104);
    check("bp_seq2", popped_pc[2], 32'h108);

    // Redirect with two requests in flight on a 3-cycle memory.
    do_reset();
    lat = 3;
    run(2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h3002);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    check("rd_bppc", o_bppc, 32'h3000);
    check("rd_req_wait", z(o_req), 32'd0);
    run(10, 1'b1);
    check("rd_first", popped_pc[0], 32'h3000);

    // Redirect coincident with a response and a decode pop.
    do_reset();
    run(2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h500);
    check("co_head_valid", z(o_fv), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    check("co_flushed", z(o_fv), 32'd0);
    run(6, 1'b1);
    check("co_seq0", popped_pc[0], 32'h100);
    check("co_seq1", popped_pc[1], 32'h500);

    // PC wrap at the top of the address space.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    check("wrap_top", o_bppc, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    check("wrap_zero", o_bppc, 32'h0000_0000);

    // Randomized traffic with redirects and occasional mid-run reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      lat = int'($urandom_range(1, 4));
      if ($urandom_range(0, 499) == 0) begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      end else begin
        step(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
             ($urandom_range(0, 3) == 0), $urandom,
             ($urandom_range(0, 11) == 0), $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
